// File: rtl/led_pattern_sequencer_pkg.sv
// Shared encodings for the LED pattern sequencer: control states, pattern modes, ping-pong direction.
// Latency: n/a (types and constants only); backpressure: n/a.
package led_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROL   = 2'b00;
    localparam logic [1:0] MODE_ROR   = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PING  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_sequencer_sync.sv
// Brings an asynchronous level into I_CLK and emits a one-cycle pulse on each synchronised rising edge.
// Latency: O_RISE is high SYNC_STAGES edges after the first edge that samples 1; no backpressure.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic I_CLK,
    input  logic I_RST_N,
    input  logic I_D,
    output logic O_RISE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_D};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign O_RISE = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Advances a mode-selected LED pattern on each synchronised divider rising edge under run/pause/clear control.
// Latency: O_LED/O_STEP update SYNC_STAGES+1 edges after the divider edge is first sampled; no backpressure.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int LED_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_DIV_CLK,
    input  logic [1:0]       I_MODE,
    input  logic             I_START,
    input  logic             I_CLEAR,
    output logic [LED_W-1:0] O_LED,
    output logic             O_STEP,
    output logic             O_RUN
);

    state_t           state_q, state_nxt;
    logic [LED_W-1:0] led_q, led_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic             dir_q, dir_nxt;
    logic             step_q, step_nxt;
    logic             run_q;
    logic             step_raw;
    logic             ping_left;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_D     (I_DIV_CLK),
        .O_RISE  (step_raw)
    );

    function automatic logic [LED_W-1:0] seed(input logic [1:0] m);
        case (m)
            MODE_ROR:   seed = {1'b1, {(LED_W-1){1'b0}}};
            MODE_BLINK: seed = '1;
            default:    seed = {{(LED_W-1){1'b0}}, 1'b1};
        endcase
    endfunction

    always_comb begin
        state_nxt = state_q;
        led_nxt   = led_q;
        mode_nxt  = mode_q;
        dir_nxt   = dir_q;
        step_nxt  = 1'b0;
        // Bounce off whichever end is lit so an end LED is never skipped or repeated.
        ping_left = (dir_q == DIR_LEFT) ? ~led_q[LED_W-1] : led_q[0];

        if (I_CLEAR) begin
            state_nxt = ST_IDLE;
            led_nxt   = '0;
            dir_nxt   = DIR_LEFT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_nxt = '0;
                    if (I_START) begin
                        state_nxt = ST_RUN;
                        led_nxt   = seed(I_MODE);
                        mode_nxt  = I_MODE;
                        dir_nxt   = DIR_LEFT;
                    end
                end
                ST_RUN: begin
                    if (I_START) begin
                        state_nxt = ST_PAUSE;
                    end else if (step_raw) begin
                        step_nxt = 1'b1;
                        if (I_MODE != mode_q) begin
                            led_nxt  = seed(I_MODE);
                            mode_nxt = I_MODE;
                            dir_nxt  = DIR_LEFT;
                        end else begin
                            case (mode_q)
                                MODE_ROL:   led_nxt = {led_q[LED_W-2:0], led_q[LED_W-1]};
                                MODE_ROR:   led_nxt = {led_q[0], led_q[LED_W-1:1]};
                                MODE_BLINK: led_nxt = ~led_q;
                                default: begin
                                    led_nxt = ping_left ? (led_q << 1) : (led_q >> 1);
                                    dir_nxt = ping_left ? DIR_LEFT : DIR_RIGHT;
                                end
                            endcase
                        end
                    end
                end
                ST_PAUSE: begin
                    if (I_START) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    led_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            mode_q  <= MODE_ROL;
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            led_q   <= led_nxt;
            mode_q  <= mode_nxt;
            dir_q   <= dir_nxt;
            step_q  <= step_nxt;
            run_q   <= (state_nxt == ST_RUN);
        end
    end

    assign O_LED  = led_q;
    assign O_STEP = step_q;
    assign O_RUN  = run_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: step vector table plus hand-built control corner cases.
module tb_led_pattern_sequencer;

    localparam int LED_W       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             div_clk;
    logic [1:0]       mode;
    logic             start;
    logic             clear;
    logic [LED_W-1:0] led;
    logic             step;
    logic             run;

    typedef struct {
        logic [1:0]       mode;
        logic [LED_W-1:0] exp_led;
    } vec_t;

    vec_t             vecs[$];
    logic [LED_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    led_pattern_sequencer #(
        .LED_W       (LED_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .I_CLK     (clk),
        .I_RST_N   (rst_n),
        .I_DIV_CLK (div_clk),
        .I_MODE    (mode),
        .I_START   (start),
        .I_CLEAR   (clear),
        .O_LED     (led),
        .O_STEP    (step),
        .O_RUN     (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every observed step must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && step) begin
            check("step_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("step_led", led, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic div_edge(input logic exp_step, input logic [LED_W-1:0] exp_led);
        int lat;
        lat = -1;
        if (exp_step) exp_q.push_back(exp_led);
        div_clk = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (step && lat < 0) lat = i;
        end
        div_clk = 1'b0;
        tick(6);
        if (exp_step) check("step_latency", lat, SYNC_STAGES + 1);
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [LED_W-1:0] l);
        vec_t v;
        v.mode    = m;
        v.exp_led = l;
        vecs.push_back(v);
    endtask

    initial begin
        // Rotate-left run, then mode switches each reload their seed on the first step.
        add_vec(2'b00, 8'h02); add_vec(2'b00, 8'h04); add_vec(2'b00, 8'h08);
        add_vec(2'b00, 8'h10); add_vec(2'b00, 8'h20); add_vec(2'b00, 8'h40);
        add_vec(2'b00, 8'h80); add_vec(2'b00, 8'h01); add_vec(2'b00, 8'h02);
        add_vec(2'b11, 8'h01);
        add_vec(2'b11, 8'h02); add_vec(2'b11, 8'h04); add_vec(2'b11, 8'h08);
        add_vec(2'b11, 8'h10); add_vec(2'b11, 8'h20); add_vec(2'b11, 8'h40);
        add_vec(2'b11, 8'h80); add_vec(2'b11, 8'h40); add_vec(2'b11, 8'h20);
        add_vec(2'b11, 8'h10); add_vec(2'b11, 8'h08); add_vec(2'b11, 8'h04);
        add_vec(2'b11, 8'h02); add_vec(2'b11, 8'h01); add_vec(2'b11, 8'h02);
        add_vec(2'b11, 8'h04);
        add_vec(2'b01, 8'h80);
        add_vec(2'b01, 8'h40); add_vec(2'b01, 8'h20); add_vec(2'b01, 8'h10);
        add_vec(2'b01, 8'h08); add_vec(2'b01, 8'h04); add_vec(2'b01, 8'h02);
        add_vec(2'b01, 8'h01); add_vec(2'b01, 8'h80);
        add_vec(2'b10, 8'hFF); add_vec(2'b10, 8'h00); add_vec(2'b10, 8'hFF);
        add_vec(2'b00, 8'h01); add_vec(2'b00, 8'h02); add_vec(2'b00, 8'h04);
        add_vec(2'b10, 8'hFF); add_vec(2'b10, 8'h00); add_vec(2'b10, 8'hFF);

        rst_n   = 1'b0;
        div_clk = 1'b0;
        mode    = 2'b00;
        start   = 1'b0;
        clear   = 1'b0;

        // Reset held with the divider toggling: outputs stay at reset values.
        for (int i = 0; i < 8; i++) begin
            div_clk = i[0];
            @(posedge clk);
            #1;
            check("rst_led", led, 0);
            check("rst_step", step, 0);
            check("rst_run", run, 0);
        end
        div_clk = 1'b0;
        #3 rst_n = 1'b1;
        tick(4);
        check("post_rst_led", led, 0);
        check("post_rst_run", run, 0);

        // Idle: divider edges do nothing.
        div_edge(1'b0, 8'h00);
        check("idle_led", led, 0);

        // Vector table run.
        mode = 2'b00;
        pulse_start();
        check("start_seed", led, 8'h01);
        check("start_run", run, 1);
        check("start_step", step, 0);
        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            div_edge(1'b1, vecs[i].exp_led);
        end
        check("table_drained", exp_q.size(), 0);

        // Pause/resume at LED=08.
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clear_led", led, 0);
        check("clear_run", run, 0);
        mode = 2'b00;
        pulse_start();
        div_edge(1'b1, 8'h02);
        div_edge(1'b1, 8'h04);
        div_edge(1'b1, 8'h08);
        pulse_start();
        check("pause_run", run, 0);
        for (int i = 0; i < 3; i++) div_edge(1'b0, 8'h00);
        check("pause_led_held", led, 8'h08);
        pulse_start();
        check("resume_run", run, 1);
        check("resume_led", led, 8'h08);
        div_edge(1'b1, 8'h10);

        // START and CLEAR together in RUN: CLEAR wins.
        start = 1'b1; clear = 1'b1; tick(1); start = 1'b0; clear = 1'b0;
        check("prio_run", run, 0);
        check("prio_led", led, 0);

        // START from IDLE landing on the step_raw cycle: seed only, no step.
        mode    = 2'b01;
        div_clk = 1'b1;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_on_step_led", led, 8'h80);
        check("start_on_step_step", step, 0);
        check("start_on_step_run", run, 1);
        tick(3);
        div_clk = 1'b0;
        tick(6);
        div_edge(1'b1, 8'h40);

        // Ping-pong from a fresh START, then asynchronous reset mid-pattern.
        clear = 1'b1; tick(1); clear = 1'b0;
        mode = 2'b11;
        pulse_start();
        check("ping_seed", led, 8'h01);
        div_edge(1'b1, 8'h02);
        div_edge(1'b1, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_run", run, 0);
        check("async_rst_step", step, 0);
        tick(2);
        #3 rst_n = 1'b1;
        tick(4);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
